// File: rtl/controle_parametrizado.sv
// Multi-cycle control unit: latches an instruction in T0 and drives register-file, A/G, ALU and bus-mux controls in T1..T3.
// Latency: MV/MVI/MVNZ/NOP complete in 2 cycles (T0+T1), ADD/SUB/AND/SLT in 4 cycles (T0..T3); all outputs combinational.
// Backpressure: none; a new instruction is accepted only in T0 when run=1. Optional macro CONTROLE_RETIRED_CNT_EN adds the retired counter.
module controle_parametrizado #(
  parameter  int NREG     = 8,  // legal range 2..16
  localparam int REG_BITS = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int IR_W     = 3 + 2*REG_BITS
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            run,
  input  logic [IR_W-1:0] ir,
  input  logic            g_nz,
  output logic            ir_in,
  output logic [NREG-1:0] r_in,
  output logic [NREG-1:0] r_out,
  output logic            a_in,
  output logic            g_in,
  output logic            g_out,
  output logic            din_out,
  output logic [1:0]      alu_op,
  output logic            done
`ifdef CONTROLE_RETIRED_CNT_EN
  ,
  output logic [15:0]     retired
`endif
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_SLT  = 3'b101,
    OP_MVNZ = 3'b110,
    OP_NOP  = 3'b111
  } opcode_t;

  state_t              state, state_nx;
  logic [IR_W-1:0]     ir_q;
  opcode_t             opc;
  logic [REG_BITS-1:0] rx;
  logic [REG_BITS-1:0] ry;
  logic [NREG-1:0]     rx_oh;
  logic [NREG-1:0]     ry_oh;

  // Field extraction from the latched instruction; live ir is only looked at in T0.
  assign opc = opcode_t'(ir_q[IR_W-1 -: 3]);
  assign rx  = ir_q[2*REG_BITS-1 -: REG_BITS];
  assign ry  = ir_q[REG_BITS-1:0];

  // One-hot decode; an index that names no existing register (NREG not a power of 2) yields no bit.
  function automatic logic [NREG-1:0] onehot(input logic [REG_BITS-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == REG_BITS'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign rx_oh = onehot(rx);
  assign ry_oh = onehot(ry);

  // State and instruction register; the instruction is captured only on the T0 accept cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= T0;
      ir_q  <= '0;
    end else begin
      state <= state_nx;
      if (ir_in) ir_q <= ir;
    end
  end

  // Next-state and control decode; everything is forced low while reset is held so run cannot leak to ir_in.
  always_comb begin
    state_nx = state;
    ir_in    = 1'b0;
    r_in     = '0;
    r_out    = '0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    g_out    = 1'b0;
    din_out  = 1'b0;
    alu_op   = 2'b00;
    done     = 1'b0;
    if (resetn) begin
      case (state)
        T0: begin
          if (run) begin
            ir_in    = 1'b1;
            state_nx = T1;
          end
        end
        T1: begin
          case (opc)
            OP_MV: begin
              r_out    = ry_oh;
              r_in     = rx_oh;
              done     = 1'b1;
              state_nx = T0;
            end
            OP_MVI: begin
              din_out  = 1'b1;
              r_in     = rx_oh;
              done     = 1'b1;
              state_nx = T0;
            end
            OP_ADD, OP_SUB, OP_AND, OP_SLT: begin
              // First operand (X) goes to A; Y follows in T2.
              r_out    = rx_oh;
              a_in     = 1'b1;
              state_nx = T2;
            end
            OP_MVNZ: begin
              // Conditional copy on the live flag; the instruction retires either way.
              if (g_nz) begin
                r_out = ry_oh;
                r_in  = rx_oh;
              end
              done     = 1'b1;
              state_nx = T0;
            end
            OP_NOP: begin
              done     = 1'b1;
              state_nx = T0;
            end
          endcase
        end
        T2: begin
          r_out = ry_oh;
          g_in  = 1'b1;
          case (opc)
            OP_SUB:  alu_op = 2'b01;
            OP_AND:  alu_op = 2'b10;
            OP_SLT:  alu_op = 2'b11;
            default: alu_op = 2'b00;
          endcase
          state_nx = T3;
        end
        T3: begin
          g_out    = 1'b1;
          r_in     = rx_oh;
          done     = 1'b1;
          state_nx = T0;
        end
      endcase
    end
  end

`ifdef CONTROLE_RETIRED_CNT_EN
  // Retired-instruction counter; free-running wrap at 16 bits.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      retired <= 16'd0;
    end else if (done) begin
      retired <= retired + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_controle_parametrizado.sv
// Scoreboard bench for controle_parametrizado: NREG=8 and NREG=6 instances share stimulus.
// Latency: expected per-cycle controls are queued at issue time and popped on the falling edge.
// Backpressure: none; the monitor compares whenever a queued expectation is pending.
module tb_controle_parametrizado;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic        run    = 1'b0;
  logic        g_nz   = 1'b0;
  logic [8:0]  ir     = '0;

  logic        ir_in8, a_in8, g_in8, g_out8, din_out8, done8;
  logic [7:0]  r_in8, r_out8;
  logic [1:0]  alu_op8;
  logic        ir_in6, a_in6, g_in6, g_out6, din_out6, done6;
  logic [5:0]  r_in6, r_out6;
  logic [1:0]  alu_op6;
`ifdef CONTROLE_RETIRED_CNT_EN
  logic [15:0] retired8, retired6;
`endif

  always #5 clock = ~clock;

  controle_parametrizado #(.NREG(8)) u8 (
    .clock(clock), .resetn(resetn), .run(run), .ir(ir), .g_nz(g_nz),
    .ir_in(ir_in8), .r_in(r_in8), .r_out(r_out8), .a_in(a_in8), .g_in(g_in8),
    .g_out(g_out8), .din_out(din_out8), .alu_op(alu_op8), .done(done8)
`ifdef CONTROLE_RETIRED_CNT_EN
    , .retired(retired8)
`endif
  );

  controle_parametrizado #(.NREG(6)) u6 (
    .clock(clock), .resetn(resetn), .run(run), .ir(ir), .g_nz(g_nz),
    .ir_in(ir_in6), .r_in(r_in6), .r_out(r_out6), .a_in(a_in6), .g_in(g_in6),
    .g_out(g_out6), .din_out(din_out6), .alu_op(alu_op6), .done(done6)
`ifdef CONTROLE_RETIRED_CNT_EN
    , .retired(retired6)
`endif
  );

  typedef struct {
    logic [23:0] b8;
    logic [19:0] b6;
    logic        done;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_ret     = '0;

  function automatic logic [23:0] bus8();
    return {ir_in8, r_in8, r_out8, a_in8, g_in8, g_out8, din_out8, alu_op8, done8};
  endfunction

  function automatic logic [19:0] bus6();
    return {ir_in6, r_in6, r_out6, a_in6, g_in6, g_out6, din_out6, alu_op6, done6};
  endfunction

  function automatic logic [7:0] oh8(input int i);
    return (i >= 0 && i < 8) ? (8'd1 << i) : 8'd0;
  endfunction

  function automatic logic [5:0] oh6(input int i);
    return (i >= 0 && i < 6) ? (6'd1 << i) : 6'd0;
  endfunction

  // One expected cycle: wr/rd are register indices written/driven (-1 for none).
  function automatic exp_t mk(input bit irin, input int wr, input int rd, input bit a,
                              input bit gi, input bit go, input bit din,
                              input logic [1:0] alu, input bit dn);
    exp_t x;
    x.b8   = {irin, oh8(wr), oh8(rd), a, gi, go, din, alu, dn};
    x.b6   = {irin, oh6(wr), oh6(rd), a, gi, go, din, alu, dn};
    x.done = dn;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction's whole cycle-by-cycle control trace.
  task automatic model(input int op, input int x, input int y, input bit gnz);
    q.push_back(mk(1, -1, -1, 0, 0, 0, 0, 2'b00, 0));
    if (op == 0) begin
      q.push_back(mk(0, x, y, 0, 0, 0, 0, 2'b00, 1));
    end else if (op == 1) begin
      q.push_back(mk(0, x, -1, 0, 0, 0, 1, 2'b00, 1));
    end else if (op >= 2 && op <= 5) begin
      q.push_back(mk(0, -1, x, 1, 0, 0, 0, 2'b00, 0));
      q.push_back(mk(0, -1, y, 0, 1, 0, 0, 2'(op - 2), 0));
      q.push_back(mk(0, x, -1, 0, 0, 1, 0, 2'b00, 1));
    end else if (op == 6) begin
      if (gnz) q.push_back(mk(0, x, y, 0, 0, 0, 0, 2'b00, 1));
      else     q.push_back(mk(0, -1, -1, 0, 0, 0, 0, 2'b00, 1));
    end else begin
      q.push_back(mk(0, -1, -1, 0, 0, 0, 0, 2'b00, 1));
    end
  endtask

  // Called at posedge+1 of a T0 cycle. noisy: 0 hold inputs, 1 random ir/run after accept, 2 MV R7,R7 with run=0.
  task automatic issue(input int op, input int x, input int y, input bit gnz, input int noisy);
    int n;
    n    = (op >= 2 && op <= 5) ? 4 : 2;
    run  = 1'b1;
    ir   = {3'(op), 3'(x), 3'(y)};
    g_nz = gnz;
    model(op, x, y, gnz);
    for (int c = 1; c < n; c++) begin
      @(posedge clock); #1;
      if (noisy == 1) begin
        ir  = 9'($urandom);
        run = 1'($urandom);
      end else if (noisy == 2) begin
        ir  = 9'b000_111_111;
        run = 1'b0;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    ir  = 9'($urandom);
    repeat (n) begin
      q.push_back(mk(0, -1, -1, 0, 0, 0, 0, 2'b00, 0));
      @(posedge clock); #1;
    end
  endtask

  // Monitor: compare every pending expectation on the falling edge.
  always @(negedge clock) begin
    if (!resetn) begin
      exp_ret = '0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      check("ctl_nreg8", 32'(bus8()), 32'(e.b8));
      check("ctl_nreg6", 32'(bus6()), 32'(e.b6));
`ifdef CONTROLE_RETIRED_CNT_EN
      check("retired8", 32'(retired8), 32'(exp_ret));
      check("retired6", 32'(retired6), 32'(exp_ret));
`endif
      if (e.done) exp_ret = exp_ret + 16'd1;
    end
  end

  initial begin
    // Reset with run high: every output must stay low.
    resetn = 1'b0;
    run    = 1'b1;
    ir     = 9'b001_000_000;
    repeat (2) @(posedge clock);
    #2;
    check("reset_nreg8", 32'(bus8()), 32'd0);
    check("reset_nreg6", 32'(bus6()), 32'd0);
`ifdef CONTROLE_RETIRED_CNT_EN
    check("reset_retired", 32'(retired8), 32'd0);
`endif
    run = 1'b0;
    @(posedge clock); #3;
    resetn = 1'b1;
    @(posedge clock); #1;
    idle(2);

    // Directed cases.
    issue(1, 0, 0, 1'b0, 0);   // MVI R0
    issue(2, 1, 1, 1'b0, 0);   // ADD R1,R1 (run held -> back-to-back)
    issue(3, 1, 1, 1'b0, 0);   // SUB
    issue(4, 1, 1, 1'b0, 0);   // AND
    issue(5, 1, 1, 1'b0, 0);   // SLT
    issue(6, 2, 0, 1'b0, 0);   // MVNZ, G zero
    issue(6, 2, 0, 1'b1, 0);   // MVNZ, G non-zero
    issue(3, 2, 0, 1'b0, 2);   // SUB R2,R0 while ir/run change mid-flight
    idle(2);                   // no MV may follow
    issue(0, 6, 0, 1'b0, 0);   // MV R6,R0: out of range on the NREG=6 copy
    issue(0, 7, 7, 1'b0, 0);   // X=Y
    issue(7, 3, 4, 1'b1, 0);   // reserved opcode
    idle(1);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), $urandom_range(0, 1));
    end

    // Reset in the middle of an ADD (during T2, between edges).
    run  = 1'b1;
    ir   = 9'b010_011_101;
    g_nz = 1'b0;
    q.push_back(mk(1, -1, -1, 0, 0, 0, 0, 2'b00, 0));
    q.push_back(mk(0, -1, 3, 1, 0, 0, 0, 2'b00, 0));
    @(posedge clock); #1;      // T1
    @(posedge clock); #1;      // T2
    #2;
    resetn = 1'b0;
    #1;
    check("midreset_nreg8", 32'(bus8()), 32'd0);
    check("midreset_nreg6", 32'(bus6()), 32'd0);
`ifdef CONTROLE_RETIRED_CNT_EN
    check("midreset_retired", 32'(retired8), 32'd0);
`endif
    run = 1'b0;
    @(posedge clock); #3;
    resetn = 1'b1;
    @(posedge clock); #1;
    idle(3);

    for (int i = 0; i < 20; i++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1);
    end
    idle(2);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/controle_parametrizado.md
Name: controle_parametrizado

Overview:
Parametrised multi-cycle control unit for the simple processor. It latches a 3-bit-opcode instruction and sequences T0..T3 steps, driving one-hot register enables/selects, A/G register loads, the ALU operation and bus-source selects. It is the next generation of the 8-register MV/MVI/ADD/SUB controller: register count is generic, the IR is latched internally, and it adds AND, SLT and conditional move MVNZ. It sits between the instruction source and the datapath (register file, A, G, ALU, bus mux).

Parameters:
NREG, 8, number of general registers; legal range 2..16
REG_BITS, $clog2(NREG), width of each register field in IR (derived, not overridden)
IR_W, 3+2*REG_BITS, instruction width: opcode[IR_W-1 -: 3], X field, Y field (LSBs)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  reset, asynchronous, active-low
run  in  1  start request, sampled in T0
ir  in  IR_W  instruction III XXX YYY / III XXX DDD
g_nz  in  1  datapath flag: G register non-zero
ir_in  out  1  instruction captured this cycle
r_in  out  NREG  one-hot register write enable
r_out  out  NREG  one-hot register bus drive
a_in  out  1  load A
g_in  out  1  load G
g_out  out  1  G drives bus
din_out  out  1  DIN drives bus
alu_op  out  2  00 add, 01 sub, 10 and, 11 slt (set-less-than, signed)
done  out  1  instruction completes this cycle

Behaviour:
- Clock and reset: single clock `clock`; reset `resetn` is asynchronous, active-low.
- Reset: state=T0, internal ir_q=0. All outputs 0 immediately and while resetn=0.
- State register: T0, T1, T2, T3. All outputs are combinational from state, ir_q, run and g_nz. Outputs not listed for a step are 0, and alu_op defaults to 00.
- T0: if run=1, ir_q<=ir, ir_in=1, next T1; else stay in T0 with all outputs 0.
- From T1 onward, decode uses ir_q only. Changes on ir and run are ignored until the next T0.
- Opcodes:
  - 000 MV: T1: r_out[Y]=1, r_in[X]=1, done=1, next T0.
  - 001 MVI: T1: din_out=1, r_in[X]=1, done=1, next T0.
  - 010 ADD / 011 SUB / 100 AND / 101 SLT:
    - T1: r_out[X]=1, a_in=1.
    - T2: r_out[Y]=1, g_in=1, alu_op = 00/01/10/11 respectively.
    - T3: g_out=1, r_in[X]=1, done=1, next T0.
  - 110 MVNZ:
    - T1 with g_nz=1: r_out[Y]=1, r_in[X]=1.
    - T1 with g_nz=0: no register enables.
    - done=1 either way, next T0. g_nz is sampled combinationally in T1.
  - 111 reserved: T1 done=1 only (NOP), next T0.
- Latency: MV/MVI/MVNZ/NOP take 2 cycles (T0+T1); ALU ops take 4 cycles. done is high for exactly one cycle per instruction.
- Back-to-back: with run held at 1, a new instruction is captured in the T0 cycle right after done.
- Register index >= NREG (possible when NREG is not a power of 2): no r_in/r_out bit asserted. Sequencing and done are unchanged.
- X=Y allowed: the same bit is asserted in r_out and r_in simultaneously.
- Reset asserted mid-instruction: abort immediately to T0 with outputs 0. The instruction is not completed and no done is issued.
- At most one r_out bit, and at most one of {r_out any, g_out, din_out}, is asserted in any cycle.

Optional Feature:
CONTROLE_RETIRED_CNT_EN
- Defined: adds output port `retired` [15:0], a count of cycles with done=1.
  - Reset to 0 by resetn.
  - Wraps 0xFFFF -> 0x0000.
  - Updates on the clock edge ending the done cycle.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- NREG=8, reset then run=1, ir=001_000_000 (MVI R0): cycle0 ir_in=1; cycle1 din_out=1, r_in=8'b0000_0001, done=1; all other outputs 0.
- ir=010_001_001 (ADD R1,R1):
  - T1: r_out=8'b0000_0010, a_in=1.
  - T2: r_out=8'b0000_0010, g_in=1, alu_op=00.
  - T3: g_out=1, r_in=8'b0000_0010, done=1.
  - Repeat with 011, 100 and 101 -> alu_op 01, 10 and 11 in T2.
- ir=110_010_000 (MVNZ R2,R0): with g_nz=0, T1 gives done=1, r_in=0, r_out=0; with g_nz=1, T1 gives r_out=8'b0000_0001, r_in=8'b0000_0100, done=1.
- Start SUB R2,R0 (011_010_000), then change ir to 000_111_111 and drop run during T1/T2: SUB completes with T3 r_in=8'b0000_0100, and no MV is executed.
- Start ADD, assert resetn=0 during T2 between clock edges: all outputs go 0 before the next edge; after release, idle in T0 with no done.
- NREG=6, ir=000_110_000 (MV R6,R0): T1 gives r_out=6'b00_0001, r_in=0, done=1; with CONTROLE_RETIRED_CNT_EN, retired increments by 1.
